// File: rtl/moore_pair_detector.sv
// Registered Moore FSM that recognises the ordered symbol pair (a, b) on a
// W-bit stream, tracking lock, a saturating pair count and illegal symbols.
module moore_pair_detector #(
    parameter int W     = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     sym,
    input  logic             sym_valid,
    input  logic             clr,
    output logic             match,
    output logic             locked,
    output logic [CNT_W-1:0] match_cnt,
    output logic             err,
    output logic             err_seen
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEEN_A = 2'd1;
    localparam logic [1:0] MATCH  = 2'd2;
    localparam logic [1:0] WAIT   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic             pair_seen_q, pair_seen_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             err_seen_q, err_seen_d;
    logic             sym_illegal;

    assign sym_illegal = sym_valid && (sym != a) && (sym != b);

    // b is tested before a in SEEN_A so that a == b alternates SEEN_A <-> MATCH.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        if (sym_valid) begin
            case (state_q)
                SEEN_A: begin
                    if (sym == b)      state_d = MATCH;
                    else if (sym == a) state_d = SEEN_A;
                    else               state_d = IDLE;
                end
                default: state_d = (sym == a) ? SEEN_A : IDLE;
            endcase
        end else if (state_q == MATCH) begin
            state_d = WAIT;
        end
        if (clr) state_d = IDLE;
    end

    // pair_seen remembers that a MATCH was reached since the last IDLE visit.
    always_comb begin
        pair_seen_d = pair_seen_q;
        locked_d    = locked_q;
        cnt_d       = cnt_q;
        err_d       = sym_illegal && !clr;
        err_seen_d  = err_seen_q || err_d;
        if (state_d == MATCH) begin
            locked_d    = pair_seen_q;
            pair_seen_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end else if (state_d == IDLE) begin
            locked_d    = 1'b0;
            pair_seen_d = 1'b0;
        end
        if (clr) begin
            cnt_d      = '0;
            err_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pair_seen_q <= 1'b0;
            locked_q    <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            err_seen_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state_q     <= state_d;
            pair_seen_q <= pair_seen_d;
            locked_q    <= locked_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            err_seen_q  <= err_seen_d;
        end
    end

    assign match     = (state_q == MATCH);
    assign locked    = locked_q;
    assign match_cnt = cnt_q;
    assign err       = err_q;
    assign err_seen  = err_seen_q;

endmodule

// File: tb/tb_moore_pair_detector.sv
// Self-checking bench: directed scenarios plus random stimulus, compared
// against a stream-level reference model (armed / pair-chain bookkeeping).
module tb_moore_pair_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] a, b, sym;
    logic       sym_valid, clr;

    logic       match, locked, err, err_seen;
    logic [7:0] match_cnt;
    logic       match2, locked2, err2, err_seen2;
    logic [1:0] match_cnt2;

    always #5 clk = ~clk;

    moore_pair_detector #(.W(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .sym(sym),
        .sym_valid(sym_valid), .clr(clr), .match(match), .locked(locked),
        .match_cnt(match_cnt), .err(err), .err_seen(err_seen)
    );

    moore_pair_detector #(.W(3), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .sym(sym),
        .sym_valid(sym_valid), .clr(clr), .match(match2), .locked(locked2),
        .match_cnt(match_cnt2), .err(err2), .err_seen(err_seen2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: "armed" means an a is waiting for its b; "had_pair"
    // means a pair completed with no break in the chain since.
    bit m_armed, m_had_pair, m_match, m_locked, m_err, m_err_seen;
    int m_cnt, m_cnt2;
    int pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_had_pair = 0; m_match = 0; m_locked = 0;
        m_err = 0; m_err_seen = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic model_edge();
        bit completing, broke, illegal;
        if (clr) begin
            model_reset();
            return;
        end
        illegal    = sym_valid && sym != a && sym != b;
        completing = sym_valid && m_armed && sym == b;
        broke      = sym_valid && !completing && sym != a;
        if (sym_valid) m_armed = !completing && sym == a;
        m_match    = completing;
        m_err      = illegal;
        m_err_seen = m_err_seen || illegal;
        if (completing) begin
            m_locked   = m_had_pair;
            m_had_pair = 1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end else if (broke) begin
            m_locked   = 0;
            m_had_pair = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".match"},     32'(match),      32'(m_match));
        check({tag, ".locked"},    32'(locked),     32'(m_locked));
        check({tag, ".match_cnt"}, 32'(match_cnt),  32'(m_cnt));
        check({tag, ".err"},       32'(err),        32'(m_err));
        check({tag, ".err_seen"},  32'(err_seen),   32'(m_err_seen));
        check({tag, ".cnt2"},      32'(match_cnt2), 32'(m_cnt2));
        check({tag, ".match2"},    32'(match2),     32'(m_match));
    endtask

    task automatic step(input string tag, input logic v, input logic [2:0] s, input logic c);
        @(negedge clk);
        sym_valid = v; sym = s; clr = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        if (match) pulses++;
    endtask

    initial begin
        reset = 1'b0; a = 3'd5; b = 3'd6; sym = '0; sym_valid = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) reset = 1'b1;

        // Single pair
        step("p1a", 1, 5, 0);
        step("p1b", 1, 6, 0);
        check("p1.match_one", 32'(match), 32'd1);
        check("p1.cnt_one", 32'(match_cnt), 32'd1);
        check("p1.locked_zero", 32'(locked), 32'd0);
        step("p1gap", 0, 0, 0);
        check("p1.match_ends", 32'(match), 32'd0);

        // Three back-to-back pairs
        step("clr", 0, 0, 1);
        pulses = 0;
        step("bb1a", 1, 5, 0); step("bb1b", 1, 6, 0);
        check("bb.locked_pair1", 32'(locked), 32'd0);
        step("bb2a", 1, 5, 0); step("bb2b", 1, 6, 0);
        check("bb.locked_pair2", 32'(locked), 32'd1);
        step("bb3a", 1, 5, 0); step("bb3b", 1, 6, 0);
        check("bb.locked_pair3", 32'(locked), 32'd1);
        check("bb.cnt3", 32'(match_cnt), 32'd3);
        check("bb.pulses", 32'(pulses), 32'd3);

        // Gaps inside and after pairs
        step("clr", 0, 0, 1);
        step("g1a", 1, 5, 0);
        for (int i = 0; i < 3; i++) step("g1gap", 0, 0, 0);
        step("g1b", 1, 6, 0);
        check("gap.match1", 32'(match), 32'd1);
        step("gwait", 0, 0, 0);
        step("g2a", 1, 5, 0); step("g2gap", 0, 0, 0); step("g2b", 1, 6, 0);
        check("gap.match2", 32'(match), 32'd1);
        check("gap.locked", 32'(locked), 32'd1);
        step("gwait2", 0, 0, 0);
        check("gap.wait_keeps_lock", 32'(locked), 32'd1);

        // Illegal symbol while locked
        step("ill", 1, 2, 0);
        check("ill.err", 32'(err), 32'd1);
        check("ill.err_seen", 32'(err_seen), 32'd1);
        check("ill.locked", 32'(locked), 32'd0);
        check("ill.cnt_kept", 32'(match_cnt), 32'd2);
        step("ill_after", 0, 0, 0);
        check("ill.err_pulse", 32'(err), 32'd0);
        check("ill.sticky", 32'(err_seen), 32'd1);

        // clr beats an illegal symbol on the same edge
        step("clr_ill", 1, 2, 1);
        check("clr_ill.err", 32'(err), 32'd0);
        check("clr_ill.err_seen", 32'(err_seen), 32'd0);

        // Saturation of the 2-bit counter
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step("sat_a", 1, 5, 0);
            step("sat_b", 1, 6, 0);
            check("sat.cnt2", 32'(match_cnt2), (i < 3) ? i + 1 : 3);
        end
        check("sat.pulses", 32'(pulses), 32'd5);
        step("sat_clr", 0, 0, 1);
        check("sat_clr.all", {match2, locked2, err2, err_seen2, match_cnt2, match_cnt}, 32'd0);

        // Asynchronous reset in the middle of a pair
        step("rst_a", 1, 5, 0);
        @(negedge clk); sym_valid = 1'b0;
        #2 reset = 1'b0;
        #1 model_reset();
        check_all("rst_async");
        @(negedge clk) reset = 1'b1;
        step("rst_b", 1, 6, 0);
        check("rst.no_match", 32'(match), 32'd0);
        step("rst2a", 1, 5, 0); step("rst2b", 1, 6, 0);
        check("rst.match", 32'(match), 32'd1);
        check("rst.cnt", 32'(match_cnt), 32'd1);

        // a == b alternates SEEN_A and MATCH
        step("eq_clr", 0, 0, 1);
        b = 3'd5;
        step("eq1", 1, 5, 0); step("eq2", 1, 5, 0);
        check("eq.match", 32'(match), 32'd1);
        step("eq3", 1, 5, 0); step("eq4", 1, 5, 0);
        check("eq.locked", 32'(locked), 32'd1);
        check("eq.cnt", 32'(match_cnt), 32'd2);
        @(negedge clk) sym_valid = 1'b0;
        b = 3'd6;

        // Random stream against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [2:0] s;
            r = int'($urandom_range(99, 0));
            s = (r < 40) ? 3'd5 : (r < 80) ? 3'd6 : 3'($urandom_range(7, 0));
            step("rnd", ($urandom_range(99, 0) < 80), s, ($urandom_range(99, 0) < 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
